// File: rtl/serial2d_seq_if.sv
// serial2d_seq_if: operand/control bundle between an operand source, the
// serial2d_seq sequencer and the downstream 2D serial MAC.
//   mode, in_valid, a_in, w_in : operand pair offer and precision mode (source -> sequencer)
//   in_ready                   : sequencer can accept a pair
//   a, w                       : operands held for the MAC during an operation
//   a_sel, w_sel, sign_ctr,
//   shift_ctr, rst_mult        : per-step MAC control word
//   busy, op_done, err_mode    : status
// Modport slave is the sequencer side; master is the source/observer side.
interface serial2d_seq_if;
  logic [3:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] w_in;
  logic [7:0] a;
  logic [7:0] w;
  logic [1:0] a_sel;
  logic [1:0] w_sel;
  logic       sign_ctr;
  logic       shift_ctr;
  logic       rst_mult;
  logic       busy;
  logic       op_done;
  logic       err_mode;

  modport slave (
    input  mode, in_valid, a_in, w_in,
    output in_ready, a, w, a_sel, w_sel, sign_ctr, shift_ctr, rst_mult, busy, op_done, err_mode
  );

  modport master (
    output mode, in_valid, a_in, w_in,
    input  in_ready, a, w, a_sel, w_sel, sign_ctr, shift_ctr, rst_mult, busy, op_done, err_mode
  );
endinterface

// File: rtl/serial2d_seq.sv
// serial2d_seq: operand sequencer for the 2D multi-2bit-serial MAC.
// Accepts one activation/weight pair per handshake, holds it on a/w and emits one
// control step per cycle, walking every 2-bit digit pair in diagonal order
// (i = a_sel + w_sel) for the latched precision mode.
//   clk_fast : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   bus      : serial2d_seq_if.slave (handshake, operands, step control, status)
module serial2d_seq (
  input logic           clk_fast,
  input logic           rst,
  serial2d_seq_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] i_q, i_d;     // diagonal index
  logic [1:0] j_q, j_d;     // weight digit index
  logic [2:0] m_q, m_d;     // activation digits
  logic [2:0] n_q, n_d;     // weight digits
  logic [7:0] a_q, a_d;
  logic [7:0] w_q, w_d;
  logic       err_q, err_d;
  logic       live_q;       // low for the cycle following a reset edge

  logic [2:0] mode_m, mode_n;
  logic       mode_bad;
  logic       running;
  logic [3:0] i_last;
  logic [2:0] n_top;
  logic [2:0] j_end;
  logic       last_diag;
  logic       is_final;
  logic [2:0] i_inc;
  logic [1:0] j_start;
  logic       in_ready;
  logic       xfer;

  always_comb begin
    mode_m   = 3'd4;
    mode_n   = 3'd4;
    mode_bad = 1'b0;
    case (bus.mode)
      4'b0000: begin mode_m = 3'd4; mode_n = 3'd4; end
      4'b0111: begin mode_m = 3'd2; mode_n = 3'd2; end
      4'b1111: begin mode_m = 3'd1; mode_n = 3'd1; end
      4'b0001: begin mode_m = 3'd4; mode_n = 3'd2; end
      4'b0011: begin mode_m = 3'd4; mode_n = 3'd1; end
      default: mode_bad = 1'b1;  // falls back to 8x8
    endcase
  end

  assign running   = (state_q == RUN);
  assign i_last    = {1'b0, m_q} + {1'b0, n_q} - 4'd2;
  assign n_top     = n_q - 3'd1;
  assign j_end     = (i_q < n_top) ? i_q : n_top;
  assign last_diag = ({1'b0, j_q} == j_end);
  // The last diagonal holds only j = n-1, so its last step is the final step.
  assign is_final  = running & ({1'b0, i_q} == i_last) & last_diag;
  assign i_inc     = i_q + 3'd1;
  assign j_start   = (i_inc >= m_q) ? 2'(i_inc - m_q + 3'd1) : 2'd0;

  assign in_ready  = live_q & ~rst & (~running | is_final);
  assign xfer      = bus.in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    m_d     = m_q;
    n_d     = n_q;
    a_d     = a_q;
    w_d     = w_q;
    err_d   = err_q;
    if (xfer) begin
      state_d = RUN;
      i_d     = 3'd0;
      j_d     = 2'd0;
      m_d     = mode_m;
      n_d     = mode_n;
      a_d     = bus.a_in;
      w_d     = bus.w_in;
      err_d   = err_q | mode_bad;
    end else if (running) begin
      if (is_final) begin
        state_d = IDLE;
      end else if (last_diag) begin
        i_d = i_inc;
        j_d = j_start;
      end else begin
        j_d = j_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 3'd0;
      j_q     <= 2'd0;
      m_q     <= 3'd0;
      n_q     <= 3'd0;
      a_q     <= 8'd0;
      w_q     <= 8'd0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      m_q     <= m_d;
      n_q     <= n_d;
      a_q     <= a_d;
      w_q     <= w_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.a         = a_q;
  assign bus.w         = w_q;
  assign bus.a_sel     = running ? 2'(i_q - {1'b0, j_q}) : 2'd0;
  assign bus.w_sel     = running ? j_q : 2'd0;
  assign bus.sign_ctr  = running & ({1'b0, j_q} == n_top);
  assign bus.shift_ctr = running & last_diag & ~is_final;
  assign bus.rst_mult  = is_final;
  assign bus.op_done   = is_final;
  assign bus.busy      = running;
  assign bus.err_mode  = err_q;

endmodule

// File: tb/tb_serial2d_seq.sv
// tb_serial2d_seq: directed, table-driven bench for serial2d_seq.
module tb_serial2d_seq;

  logic clk_fast = 1'b0;
  logic rst      = 1'b1;

  serial2d_seq_if bus();

  serial2d_seq dut (
    .clk_fast (clk_fast),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_fast = ~clk_fast;

  typedef struct packed {
    logic [1:0] as;
    logic [1:0] ws;
    logic       sg;
    logic       sh;
    logic       rm;
  } step_t;

  typedef struct {
    logic [3:0] md;
    logic [7:0] a;
    logic [7:0] w;
    int         start;
    int         len;
    logic       err;
  } op_t;

  // {busy, in_ready, op_done, rst_mult, shift_ctr, sign_ctr, a_sel, w_sel}
  localparam logic [15:0] IdleWord  = 16'h0100;
  localparam logic [15:0] ResetWord = 16'h0000;

  step_t tbl [0:32];
  op_t   ops [0:4];
  int    n_pass  = 0;
  int    n_total = 0;

  function automatic step_t mk(int as, int ws, bit sg, bit sh, bit rm);
    return {2'(as), 2'(ws), sg, sh, rm};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk_fast);
    #1;
  endtask

  function automatic logic [15:0] out_word();
    return {6'd0, bus.busy, bus.in_ready, bus.op_done, bus.rst_mult, bus.shift_ctr,
            bus.sign_ctr, bus.a_sel, bus.w_sel};
  endfunction

  function automatic logic [15:0] exp_word(int idx, bit last);
    step_t s;
    s = tbl[idx];
    return {6'd0, 1'b1, last, s.rm, s.rm, s.sh, s.sg, s.as, s.ws};
  endfunction

  task automatic check_step(input string tag, input int idx, input int k, input int len,
                            input logic [7:0] ea, input logic [7:0] ew);
    chk($sformatf("%s step %0d ctrl", tag, k + 1), out_word(), exp_word(idx + k, k == len - 1));
    chk($sformatf("%s step %0d a", tag, k + 1), {8'd0, bus.a}, {8'd0, ea});
    chk($sformatf("%s step %0d w", tag, k + 1), {8'd0, bus.w}, {8'd0, ew});
  endtask

  task automatic issue(input logic [3:0] md, input logic [7:0] a, input logic [7:0] w);
    bus.mode     = md;
    bus.a_in     = a;
    bus.w_in     = w;
    bus.in_valid = 1'b1;
  endtask

  task automatic run_single(input string tag, input op_t o);
    issue(o.md, o.a, o.w);
    chk({tag, " ready before accept"}, {15'd0, bus.in_ready}, 16'd1);
    tick;
    // Disturb inputs after the transfer: none may affect the running op.
    bus.in_valid = 1'b0;
    bus.mode     = 4'b1111;
    bus.a_in     = ~o.a;
    bus.w_in     = ~o.w;
    for (int k = 0; k < o.len; k++) begin
      check_step(tag, o.start, k, o.len, o.a, o.w);
      if (k == 0) chk({tag, " err_mode"}, {15'd0, bus.err_mode}, {15'd0, o.err});
      tick;
    end
    chk({tag, " idle ctrl"}, out_word(), IdleWord);
    chk({tag, " idle a held"}, {8'd0, bus.a}, {8'd0, o.a});
    chk({tag, " idle w held"}, {8'd0, bus.w}, {8'd0, o.w});
    chk({tag, " idle err_mode"}, {15'd0, bus.err_mode}, {15'd0, o.err});
  endtask

  initial begin
    logic [7:0] pa [0:4];
    logic [7:0] pw [0:4];

    // 8x8: diagonals 00; 10,01; 20,11,02; 30,21,12,03; 31,22,13; 32,23; 33
    tbl[0]  = mk(0, 0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0);  tbl[2]  = mk(0, 1, 0, 1, 0);
    tbl[3]  = mk(2, 0, 0, 0, 0);  tbl[4]  = mk(1, 1, 0, 0, 0);  tbl[5]  = mk(0, 2, 0, 1, 0);
    tbl[6]  = mk(3, 0, 0, 0, 0);  tbl[7]  = mk(2, 1, 0, 0, 0);
    tbl[8]  = mk(1, 2, 0, 0, 0);  tbl[9]  = mk(0, 3, 1, 1, 0);
    tbl[10] = mk(3, 1, 0, 0, 0);  tbl[11] = mk(2, 2, 0, 0, 0);  tbl[12] = mk(1, 3, 1, 1, 0);
    tbl[13] = mk(3, 2, 0, 0, 0);  tbl[14] = mk(2, 3, 1, 1, 0);
    tbl[15] = mk(3, 3, 1, 0, 1);
    // A8xW4: 00; 10,01; 20,11; 30,21; 31
    tbl[16] = mk(0, 0, 0, 1, 0);
    tbl[17] = mk(1, 0, 0, 0, 0);  tbl[18] = mk(0, 1, 1, 1, 0);
    tbl[19] = mk(2, 0, 0, 0, 0);  tbl[20] = mk(1, 1, 1, 1, 0);
    tbl[21] = mk(3, 0, 0, 0, 0);  tbl[22] = mk(2, 1, 1, 1, 0);
    tbl[23] = mk(3, 1, 1, 0, 1);
    // A8xW2: single weight digit, always the sign digit
    tbl[24] = mk(0, 0, 1, 1, 0);  tbl[25] = mk(1, 0, 1, 1, 0);
    tbl[26] = mk(2, 0, 1, 1, 0);  tbl[27] = mk(3, 0, 1, 0, 1);
    // 4x4: 00; 10,01; 11
    tbl[28] = mk(0, 0, 0, 1, 0);
    tbl[29] = mk(1, 0, 0, 0, 0);  tbl[30] = mk(0, 1, 1, 1, 0);
    tbl[31] = mk(1, 1, 1, 0, 1);
    // 2x2
    tbl[32] = mk(0, 0, 1, 0, 1);

    ops[0] = '{md: 4'b0000, a: 8'hB3, w: 8'h9C, start: 0,  len: 16, err: 1'b0};
    ops[1] = '{md: 4'b0001, a: 8'hC5, w: 8'hA0, start: 16, len: 8,  err: 1'b0};
    ops[2] = '{md: 4'b0011, a: 8'hE7, w: 8'h40, start: 24, len: 4,  err: 1'b0};
    ops[3] = '{md: 4'b0111, a: 8'h50, w: 8'hD0, start: 28, len: 4,  err: 1'b0};
    ops[4] = '{md: 4'b0101, a: 8'h6A, w: 8'h81, start: 0,  len: 16, err: 1'b1};

    pa[0] = 8'h40; pa[1] = 8'h80; pa[2] = 8'hC0; pa[3] = 8'h00; pa[4] = 8'h40;
    pw[0] = 8'hC0; pw[1] = 8'h40; pw[2] = 8'h80; pw[3] = 8'hC0; pw[4] = 8'h00;

    bus.mode = 4'b0000; bus.in_valid = 1'b0; bus.a_in = 8'h00; bus.w_in = 8'h00;

    // Reset state.
    rst = 1'b1;
    tick;
    tick;
    chk("reset ctrl", out_word(), ResetWord);
    chk("reset a", {8'd0, bus.a}, 16'd0);
    chk("reset w", {8'd0, bus.w}, 16'd0);
    chk("reset err_mode", {15'd0, bus.err_mode}, 16'd0);
    rst = 1'b0;
    tick;
    chk("ready after reset", out_word(), IdleWord);

    // Single operations in every mode; the illegal mode comes last.
    for (int t = 0; t < 5; t++) run_single($sformatf("op%0d", t), ops[t]);

    tick;
    chk("err_mode sticky", {15'd0, bus.err_mode}, 16'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("err_mode cleared", {15'd0, bus.err_mode}, 16'd0);
    tick;

    // 2x2 streaming: in_valid held high, one single-step op per cycle.
    issue(4'b1111, pa[0], pw[0]);
    tick;
    for (int p = 0; p < 5; p++) begin
      check_step($sformatf("2x2 pair%0d", p), 32, 0, 1, pa[p], pw[p]);
      if (p < 4) issue(4'b1111, pa[p + 1], pw[p + 1]);
      else bus.in_valid = 1'b0;
      tick;
    end
    chk("2x2 idle ctrl", out_word(), IdleWord);

    // 4x4 back-to-back with no bubble.
    issue(4'b0111, 8'h50, 8'h70);
    tick;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_step("4x4 first", 28, k, 4, 8'h50, 8'h70);
      if (k == 3) issue(4'b0111, 8'hA4, 8'hC8);
      tick;
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_step("4x4 second", 28, k, 4, 8'hA4, 8'hC8);
      tick;
    end
    chk("4x4 idle ctrl", out_word(), IdleWord);
    chk("4x4 idle a held", {8'd0, bus.a}, 16'h00A4);

    // Reset during step 7 of an 8x8 op, then restart.
    issue(4'b0000, 8'h5A, 8'h3C);
    tick;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check_step("abort", 0, k, 16, 8'h5A, 8'h3C);
      if (k < 6) tick;
    end
    rst = 1'b1;
    tick;
    chk("abort reset ctrl", out_word(), ResetWord);
    chk("abort reset a", {8'd0, bus.a}, 16'd0);
    chk("abort reset w", {8'd0, bus.w}, 16'd0);
    rst = 1'b0;
    tick;
    chk("abort ready", out_word(), IdleWord);
    run_single("restart", '{md: 4'b0000, a: 8'h1F, w: 8'hE2, start: 0, len: 16, err: 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial2d_seq.md
# serial2d_seq

Operand sequencer that drives the 2D multi-2bit-serial MAC (`top_mac_serial2d`). It accepts one activation/weight pair per handshake and holds the operands stable on the MAC inputs. For that pair it emits the per-cycle control word (`a_sel`, `w_sel`, `sign_ctr`, `shift_ctr`, `rst_mult`) that walks every 2-bit digit pair in diagonal order for the configured precision mode. It sits directly upstream of the MAC in the `clk_fast` domain and generates in hardware the control sequence that benches currently produce by hand.

## Interface
- No parameters; digit width fixed at 2 bits, operands at 8 bits.
- `clk_fast` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mode` in 4: precision mode, sampled only on accept. `0000` 8x8, `0111` 4x4, `1111` 2x2, `0001` A8xW4, `0011` A8xW2.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: sequencer can accept.
- `a_in` in 8: unsigned activation, MSB-aligned, zero-padded LSBs.
- `w_in` in 8: signed weight, MSB-aligned.
- `a`, `w` out 8 each: registered operands to the MAC, held for the whole operation.
- `a_sel`, `w_sel` out 2 each: digit indices for the current step.
- `sign_ctr` out 1: current weight digit is the sign digit.
- `shift_ctr` out 1: the accumulator shifts after this step.
- `rst_mult` out 1: marks the last step of an operation.
- `busy` out 1: a step is being emitted.
- `op_done` out 1: one-cycle pulse with the last step.
- `err_mode` out 1: sticky illegal-mode flag.

## Operation
- Digit counts are fixed per mode, with m = activation digits and n = weight digits:
  - `0000`: m=4, n=4
  - `0111`: m=2, n=2
  - `1111`: m=1, n=1
  - `0001`: m=4, n=2
  - `0011`: m=4, n=1
- Any other mode on accept is treated as `0000`, and `err_mode` is set. Only `rst` clears `err_mode`.
- States are IDLE and RUN. Counters are i (diagonal, 0..m+n-2) and j (weight digit).
- A transfer occurs when `in_valid & in_ready`. On transfer: latch `a_in`→`a`, `w_in`→`w`, latch m/n, set i=0 and j=0, and enter RUN.
- In RUN, each cycle emits one step:
  - `a_sel = i-j`, `w_sel = j`
  - `sign_ctr = (j == n-1)`
- Within a diagonal, j runs from max(0, i-m+1) to min(i, n-1). Then i increments and j restarts at max(0, i+1-m+1).
- `shift_ctr` = 1 on the last step of diagonal i for i < m+n-2; otherwise 0.
- `rst_mult` = 1 and `op_done` = 1 on the final step (i = m+n-2, j = n-1).
- An operation always takes m·n steps: 16, 4, 1, 8, 4 for the five modes.
- `in_ready` = 1 in IDLE and on the final RUN step; 0 otherwise and during reset.
  - A transfer on the final step starts the next operation on the following cycle, with no bubble.
  - With no transfer, the block returns to IDLE.
- In IDLE, the step outputs are 0 and `a`/`w` hold their last values.

## Timing
- Reset value of every output is 0 (including `a`, `w` and `in_ready`). `in_ready` rises in the first cycle after `rst` deasserts.
- Step outputs are registered. A transfer at edge k produces the first step valid in cycle k+1. The last step of an m·n-step operation is valid in cycle k+m·n.
- Throughput is one operation per m·n cycles when `in_valid` is held high.
- If `rst` is asserted mid-operation, the operation is abandoned: next cycle IDLE, all outputs 0, no `op_done`.
- `mode` changes while in RUN have no effect on the current operation.
- `in_valid` may drop at any time. Operands are captured only on a transfer cycle.

## Test plan
- 8x8 (`0000`), `a_in`=0xB3, `w_in`=0x9C → 16 steps with (a_sel,w_sel) order 00; 10,01; 20,11,02; 30,21,12,03; 31,22,13; 32,23; 33.
  - `shift_ctr` on steps 1, 3, 6, 10, 13, 15.
  - `sign_ctr` on the w_sel=3 steps.
  - `rst_mult` and `op_done` on step 16.
  - `a`=0xB3 and `w`=0x9C stable throughout.
- A8xW4 (`0001`) → 8 steps: 00; 10,01; 20,11; 30,21; 31.
  - `shift_ctr` on steps 1, 3, 5, 7.
  - `sign_ctr` on steps 3, 5, 7, 8.
- 2x2 (`1111`), `in_valid` held high with 5 distinct pairs → 5 consecutive single-step cycles.
  - Each step: a_sel=w_sel=0, `sign_ctr`=1, `rst_mult`=1, `shift_ctr`=0.
  - `in_ready` constantly 1.
  - `a`/`w` update every cycle.
- 4x4 (`0111`) back-to-back pair, then `in_valid` low → 4+4 steps with no gap, then IDLE with all step outputs 0 and `busy`=0.
- `rst` pulsed on step 7 of a 16-step 8x8 op → next cycle all outputs 0, no `op_done`; a new transfer restarts at step 00.
- `mode`=`0101` on accept → 16-step 8x8 sequence and `err_mode`=1, held until `rst`.
